// File: rtl/sbox_lut_loader.sv
// Write-side sequencer for the programmable ASCON S-box LUT: takes DEPTH entries
// over valid/ready and issues one registered LUT write per accepted entry.
module sbox_lut_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              upd_sbox_o,
  output logic [ADDR_W-1:0] sbox_addr_o,
  output logic [DATA_W-1:0] sbox_new_data_o,
  output logic              lut_busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [ADDR_W:0]   load_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              accept_s;

  // Ready depends only on state so the upstream never sees a valid->ready loop.
  assign in_ready_o = (state_r == LOAD);
  assign accept_s   = in_valid_i & in_ready_o;

  // Load sequencer: state, write index and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      idx_r           <= '0;
      upd_sbox_o      <= 1'b0;
      sbox_addr_o     <= '0;
      sbox_new_data_o <= '0;
      lut_busy_o      <= 1'b0;
      done_o          <= 1'b0;
      aborted_o       <= 1'b0;
      load_cnt_o      <= '0;
    end else begin
      upd_sbox_o <= 1'b0;
      done_o     <= 1'b0;
      aborted_o  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r    <= LOAD;
            idx_r      <= '0;
            load_cnt_o <= '0;
            lut_busy_o <= 1'b1;
          end else begin
            lut_busy_o <= 1'b0;
          end
        end
        LOAD: begin
          // Abort takes priority and swallows any write from a same-edge accept.
          if (abort_i) begin
            state_r    <= IDLE;
            aborted_o  <= 1'b1;
            lut_busy_o <= 1'b0;
          end else if (accept_s) begin
            upd_sbox_o      <= 1'b1;
            sbox_addr_o     <= idx_r;
            sbox_new_data_o <= in_data_i;
            idx_r           <= idx_r + ADDR_W'(1);
            load_cnt_o      <= load_cnt_o + (ADDR_W + 1)'(1);
            if (idx_r == LAST_IDX) begin
              state_r <= FLUSH;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        FLUSH: begin
          state_r    <= IDLE;
          lut_busy_o <= 1'b0;
          if (abort_i) begin
            aborted_o <= 1'b1;
          end else begin
            done_o <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          lut_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
